instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream neighbour of the main/ALU control decoders: owns the PC, fetches from
//  instruction memory over a req/ack handshake and presents one instruction at a
//  time to decode. Resolves next-PC (PC+4 or BEQ target) from decode's nPC_Sel
//  and the ALU zero flag. Supports variable memory latency and decode stall.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  ADDR_W       32             PC / imem address width
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  imem_req     out  1       fetch request, held until imem_ack
//  imem_addr    out  ADDR_W  fetch address (= pc_q), stable while imem_req
//  imem_ack     in   1       read data valid this cycle
//  imem_rdata   in   32      instruction word, sampled when imem_req && imem_ack
//  instr        out  32      held instruction to decode (opCode=[31:26], funct=[5:0])
//  instr_valid  out  1       instr is valid
//  instr_ready  in   1       decode/execute done with instr this cycle
//  npc_sel      in   1       from main control: instruction is BEQ
//  alu_zero     in   1       ALU zero flag for held instr
//  pc           out  ADDR_W  address of held instr (pc_q)
//  fetch_count  out  32      instructions retired (handshakes completed)
// BEHAVIOUR
//  - States: IDLE -> REQ -> HOLD -> REQ ...; encoded in a 2-bit state reg.
//  - Reset (async, any time): state=IDLE, pc_q=RESET_PC, instr=0, instr_valid=0,
//    imem_req=0, fetch_count=0. Any in-flight fetch is abandoned; a late
//    imem_ack after reset is ignored unless state is REQ.
//  - IDLE: imem_req=0; always moves to REQ on next edge (first req 1 cycle after
//    reset deasserts).
//  - REQ: imem_req=1, imem_addr=pc_q. On imem_ack: instr<=imem_rdata,
//    instr_valid<=1, -> HOLD. Ack allowed in same cycle req first rises
//    (zero-wait memory => 1 cycle REQ). imem_ack outside REQ ignored.
//  - HOLD: imem_req=0, instr/instr_valid/pc stable. On instr_ready:
//    taken = npc_sel & alu_zero (sampled this cycle only);
//    pc_q <= taken ? pc_q+4+(sext(instr[15:0])<<2) : pc_q+4;
//    instr_valid<=0, fetch_count<=fetch_count+1, -> REQ.
//    instr_ready low: stay in HOLD indefinitely, no new request.
//  - instr_ready while not HOLD: ignored. npc_sel/alu_zero outside HOLD: ignored.
//  - Arithmetic: all PC math modulo 2^ADDR_W; 0xFFFF_FFFC+4 wraps to 0.
//    Offset sign-extended from bit 15 before shift. fetch_count wraps 2^32-1->0.
//  - Latency: instruction accepted at cycle N -> next imem_req at N+1; with
//    zero-wait memory, one instruction per 2 cycles.
//  - Unaligned PC not possible (RESET_PC must be word aligned; bits[1:0] stay 0).
//  - All outputs registered except imem_req/imem_addr (decoded from state/pc_q).
// TESTING
//  1 Reset release, ack tied 1 -> cycle1 req=1 addr=0x0, addrs 0x0,0x4,0x8 with
//    instr_ready=1; fetch_count=3 after three HOLD handshakes.
//  2 Ack latency 0,1,3 cycles -> addr stable during wait, instr = rdata at ack.
//  3 pc=0x10, instr imm=0x0003, npc_sel=1 zero=1 -> next addr 0x20; zero=0 -> 0x14;
//    imm=0xFFFF zero=1 -> 0x10.
//  4 RESET_PC=0xFFFF_FFFC, sequential -> next addr 0x0000_0000.
//  5 instr_ready low 5 cycles in HOLD -> no req, instr/pc unchanged; then 1 -> REQ.
//  6 reset asserted mid-REQ with ack pending -> outputs reset same cycle; stale
//    ack ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per req/ack handshake
// and holds it for decode until instr_ready, then resolves PC+4 or BEQ target.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              npc_sel,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } stateT;

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  stateT             state;
  stateT             nextState;
  logic [ADDR_W-1:0] pcQ;
  logic [ADDR_W-1:0] pcNext;
  logic [ADDR_W-1:0] branchOffset;
  logic              acceptWord;
  logic              retire;
  logic              taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = REQ;
      REQ:     if (imem_ack) nextState = HOLD;
      HOLD:    if (instr_ready) nextState = REQ;
      default: nextState = IDLE;
    endcase
  end

  // Request and address are decoded straight from state so a zero-wait
  // memory can ack in the very cycle the request first rises.
  always_comb begin
    imem_req   = (state == REQ);
    imem_addr  = pcQ;
    acceptWord = (state == REQ) && imem_ack;
    retire     = (state == HOLD) && instr_ready;
  end

  // Branch offset is the word offset of the held instruction, sign-extended.
  always_comb begin
    taken        = npc_sel & alu_zero;
    branchOffset = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    pcNext       = taken ? (pcQ + WORD_BYTES + branchOffset) : (pcQ + WORD_BYTES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcQ         <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (acceptWord) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        pcQ         <= pcNext;
        instr_valid <= 1'b0;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  assign pc = pcQ;

endmodule
